// File: rtl/l2_line_transfer_unit.sv
// Moves 256-bit L2 lines between 64-bit memory and the four way data arrays:
// it assembles fill lines from four memory beats and serializes victim lines into four beats.
module l2_line_transfer_unit #(
    parameter int LINE_WIDTH  = 256,
    parameter int BEAT_WIDTH  = 64,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fill_req,
    input  logic                   wb_req,
    input  logic [31:0]            fill_addr,
    input  logic [31:0]            wb_addr,
    input  logic [INDEX_WIDTH-1:0] req_index,
    input  logic [1:0]             req_way,
    input  logic [LINE_WIDTH-1:0]  wb_data,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [31:0]            mem_address,
    output logic [BEAT_WIDTH-1:0]  mem_wdata,
    input  logic [BEAT_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_resp,
    output logic [3:0]             arr_write,
    output logic [INDEX_WIDTH-1:0] arr_index,
    output logic [LINE_WIDTH-1:0]  arr_datain
);

    typedef enum logic [1:0] {IDLE, WB, FILL, FINISH} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             beat_q, beat_d;
    logic [26:0]            fill_line_addr_q, fill_line_addr_d;
    logic [26:0]            wb_line_addr_q, wb_line_addr_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [1:0]             way_q, way_d;
    logic [LINE_WIDTH-1:0]  victim_q, victim_d;
    logic [LINE_WIDTH-1:0]  line_q, line_d;
    logic                   do_fill_q, do_fill_d;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [31:0]            mem_address_q, mem_address_d;
    logic [BEAT_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [3:0]             arr_write_q, arr_write_d;
    logic [INDEX_WIDTH-1:0] arr_index_q, arr_index_d;
    logic [LINE_WIDTH-1:0]  arr_datain_q, arr_datain_d;

    // Line offset bits never reach the beat address.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fill_addr[4:0], wb_addr[4:0]};

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        fill_line_addr_d = fill_line_addr_q;
        wb_line_addr_d   = wb_line_addr_q;
        index_d          = index_q;
        way_d            = way_q;
        victim_d         = victim_q;
        line_d           = line_q;
        do_fill_d        = do_fill_q;

        case (state_q)
            IDLE: begin
                if (fill_req || wb_req) begin
                    fill_line_addr_d = fill_addr[31:5];
                    wb_line_addr_d   = wb_addr[31:5];
                    index_d          = req_index;
                    way_d            = req_way;
                    victim_d         = wb_data;
                    do_fill_d        = fill_req;
                    beat_d           = 2'd0;
                    state_d          = wb_req ? WB : FILL;
                end
            end
            WB: begin
                if (mem_resp) begin
                    if (beat_q == 2'd3) begin
                        beat_d  = 2'd0;
                        state_d = do_fill_q ? FILL : FINISH;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            FILL: begin
                if (mem_resp) begin
                    line_d[int'(beat_q) * BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
                    if (beat_q == 2'd3) begin
                        beat_d  = 2'd0;
                        state_d = FINISH;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so they are valid the cycle the state is entered.
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == FINISH);
        mem_write_d   = (state_d == WB);
        mem_read_d    = (state_d == FILL);
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        arr_write_d   = 4'b0000;
        arr_index_d   = arr_index_q;
        arr_datain_d  = arr_datain_q;

        if (state_d == WB) begin
            mem_address_d = {wb_line_addr_d, beat_d, 3'b000};
            mem_wdata_d   = victim_d[int'(beat_d) * BEAT_WIDTH +: BEAT_WIDTH];
        end else if (state_d == FILL) begin
            mem_address_d = {fill_line_addr_d, beat_d, 3'b000};
        end

        if (state_d == FINISH) begin
            arr_index_d = index_d;
            if (do_fill_d) begin
                arr_write_d  = 4'b0001 << way_d;
                arr_datain_d = line_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            beat_q           <= '0;
            fill_line_addr_q <= '0;
            wb_line_addr_q   <= '0;
            index_q          <= '0;
            way_q            <= '0;
            victim_q         <= '0;
            line_q           <= '0;
            do_fill_q        <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_wdata_q      <= '0;
            arr_write_q      <= '0;
            arr_index_q      <= '0;
            arr_datain_q     <= '0;
        end else begin
            state_q          <= state_d;
            beat_q           <= beat_d;
            fill_line_addr_q <= fill_line_addr_d;
            wb_line_addr_q   <= wb_line_addr_d;
            index_q          <= index_d;
            way_q            <= way_d;
            victim_q         <= victim_d;
            line_q           <= line_d;
            do_fill_q        <= do_fill_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_wdata_q      <= mem_wdata_d;
            arr_write_q      <= arr_write_d;
            arr_index_q      <= arr_index_d;
            arr_datain_q     <= arr_datain_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign arr_write   = arr_write_q;
    assign arr_index   = arr_index_q;
    assign arr_datain  = arr_datain_q;

endmodule

// File: doc/l2_line_transfer_unit.md
Name: l2_line_transfer_unit

Overview:
- Moves whole 256-bit L2 lines between 64-bit physical memory and the 4-way L2 data arrays.
- Fill: collects four memory beats into one line, then issues one single-cycle write to the selected way's array at the given index.
- Writeback: serializes a captured dirty victim line to memory as four beats.
- Driven by the L2 controller; directly feeds the per-way data arrays' write/index/datain inputs.

Parameters:
LINE_WIDTH, 256, line width; equals data array width
BEAT_WIDTH, 64, memory beat width; LINE_WIDTH/BEAT_WIDTH = 4 beats
INDEX_WIDTH, 4, set index width (16 sets)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
fill_req  in  1  request line fill; sampled only in IDLE
wb_req  in  1  request victim writeback; sampled only in IDLE
fill_addr  in  32  fill line address; bits [4:0] ignored
wb_addr  in  32  victim line address; bits [4:0] ignored
req_index  in  INDEX_WIDTH  target set
req_way  in  2  target way
wb_data  in  LINE_WIDTH  victim line from the arrays
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  32  beat address
mem_wdata  out  BEAT_WIDTH  writeback beat
mem_rdata  in  BEAT_WIDTH  fill beat
mem_resp  in  1  beat accepted/returned this cycle
arr_write  out  4  one-hot per-way array write enable
arr_index  out  INDEX_WIDTH  array index
arr_datain  out  LINE_WIDTH  assembled fill line

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, mem_read, mem_write, arr_write = 0; mem_address, mem_wdata, arr_index, beat counter = 0. A partial line is discarded; no array write occurs.
- States: IDLE, WB, FILL, FINISH.
- IDLE, acceptance:
  - Acceptance edge is any posedge with fill_req|wb_req = 1.
  - Registers fill_addr, wb_addr, req_index, req_way, wb_data, and flags do_fill/do_wb.
  - Next state: WB if wb_req, else FILL.
  - Later changes on request inputs do not affect the operation.
- busy: 1 in every non-IDLE cycle, 0 in IDLE.
- Beat addressing: mem_address = {line_addr[31:5], beat[1:0], 3'b000}.
  - Beat 0 maps to line bits [63:0]; beat k maps to [64k+63:64k].
- WB state:
  - mem_write = 1 with mem_wdata = captured victim beat k.
  - Address and data are held until a posedge with mem_resp = 1.
  - The counter then advances and the next beat is presented the following cycle; the strobe stays high between beats.
  - After beat 3 resp: go to FILL if do_fill (mem_write 0, mem_read 1 next cycle, counter 0), else FINISH.
- FILL state:
  - mem_read = 1, address held until mem_resp.
  - On a mem_resp posedge, mem_rdata is stored into line slice k.
  - After beat 3: go to FINISH.
- FINISH (exactly one cycle):
  - done = 1; mem strobes 0; arr_index = captured index.
  - If do_fill: arr_write = one-hot(captured way) and arr_datain = assembled line. Else arr_write = 0.
  - Next state: IDLE.
- Latency with mem_resp in every strobe cycle, acceptance at edge T:
  - Fill-only: strobe cycles T+1..T+4, FINISH at T+5, IDLE at T+6.
  - WB+fill: FINISH at T+9.
  - WB-only: FINISH at T+5.
- Simultaneous requests: writeback always precedes fill (eviction order). Both use the same index/way.
- Ignored inputs: fill_req/wb_req while busy, and mem_resp in IDLE or FINISH.
- Never asserted: mem_read and mem_write together, or more than one arr_write bit.
- Outputs are registered; arr_datain holds its value outside FINISH but is meaningful only when arr_write ≠ 0.

Test Plan:
- Fill-only, index 5, way 2, fill_addr 0x0000_1240, beats 0x11..11/0x22..22/0x33..33/0x44..44, zero-wait resp:
  - mem_address sequence 0x1240, 0x1248, 0x1250, 0x1258.
  - FINISH at T+5 with arr_write=4'b0100, arr_index=5, arr_datain={0x44..,0x33..,0x22..,0x11..}, done=1.
- WB-only, wb_addr 0x0000_2000, wb_data=256'h0123..: four mem_write beats at 0x2000..0x2018 carrying slices low-to-high; done at T+5; arr_write stays 0.
- WB+fill simultaneous, 3-cycle resp latency per beat:
  - Strobes and address held across waits; mem_write never overlaps mem_read.
  - Transition WB→FILL has no idle cycle; single array write at end; done once.
- Reset mid-fill: assert rst_n=0 after beat 2 resp → all outputs 0 immediately, no arr_write, IDLE. A new fill then completes normally with fresh data.
- Request during busy: pulse fill_req with different addr/way mid-operation → ignored; only the original operation's address and way appear.
- Back-to-back: fill_req held high → second operation accepted on the edge after FINISH (at the IDLE cycle); busy low for exactly one cycle between.
